// File: rtl/result_checker_pkg.sv
// Shared definitions for result_checker: FSM encoding, datapath widths,
// default timeout length and the odd-parity helper.
package result_checker_pkg;

    localparam int DATA_W  = 16;
    localparam int POP_W   = 6;
    localparam int SHREG_W = 2 * DATA_W;
    localparam int CNT_W   = 5;
    localparam int TO_W    = 24;

    localparam logic [TO_W-1:0] TIMEOUT_DEFAULT = 24'd10_000_000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_TOUT  = 3'd4
    } state_t;

    // Odd parity over a population count: pop + parity is always odd.
    function automatic logic odd_parity(input logic [POP_W-1:0] p);
        return ~p[0];
    endfunction

endpackage

// File: rtl/result_checker_serial_pop_count.sv
// serial_pop_count: bit-serial population count over a 32-bit word.
// Handshake: load (one cycle) starts a run and raises busy; busy stays high
// for exactly 32 shift cycles; finish is high during the last of them.
// clear aborts a run and zeroes the accumulator.
module serial_pop_count
    import result_checker_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [SHREG_W-1:0] din,
    output logic               busy,
    output logic               finish,
    output logic [POP_W-1:0]   pop
);

    logic [SHREG_W-1:0] shreg;
    logic [CNT_W-1:0]   cnt;

    // Shift the MSB out each busy cycle and accumulate it into pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
            pop   <= '0;
            busy  <= 1'b0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
            pop   <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            shreg <= din;
            cnt   <= '0;
            pop   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            pop   <= pop + {{(POP_W-1){1'b0}}, shreg[SHREG_W-1]};
            shreg <= shreg << 1;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                busy <= 1'b0;
            end
        end
    end

    // Last shift cycle: the accumulator is complete after this edge.
    always_comb begin
        finish = busy && (cnt == 5'd31);
    end

endmodule

// File: rtl/result_checker.sv
// result_checker: arms on start, captures g/h on a done rising edge, counts
// the ones serially and holds pop/parity with valid until start drops.
// Optional feature: define RESULT_CHECKER_TIMEOUT_EN to add an ARMED
// watchdog that moves to TOUT after TIMEOUT_CYCLES cycles without done.
// Handshake: start is a level; dropping it in any non-IDLE state returns to
// IDLE on the next edge. valid is high only while in HOLD, and pop/parity
// are stable whenever valid is high.
module result_checker
    import result_checker_pkg::*;
#(
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] h,
    input  logic              sel,
    output logic [DATA_W-1:0] disp,
    output logic [POP_W-1:0]  pop,
    output logic              parity,
    output logic              valid,
    output logic              busy,
    output logic              timeout,
    output logic [2:0]        state_dbg
);

    state_t            state, state_nxt;
    logic              done_q;
    logic              done_edge;
    logic              sp_load, sp_clear, sp_busy, sp_finish;
    logic [DATA_W-1:0] g_cap, h_cap;

    assign done_edge = done && !done_q;

`ifdef RESULT_CHECKER_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    assign to_hit = (to_cnt == TIMEOUT_CYCLES - 24'd1);

    // Watchdog counts ARMED cycles; it sits at zero everywhere else, so each
    // ARMED entry starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state != S_ARMED) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 24'd1;
        end
    end

    assign timeout = (state == S_TOUT);
`else
    // No watchdog: TOUT is unreachable; the parameter is only referenced so
    // that the interface stays identical across builds.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == '0);
`endif

    // State register and done edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done;
        end
    end

    // Next-state logic; dropping start wins over every other event.
    always_comb begin
        state_nxt = state;
        sp_load   = 1'b0;
        sp_clear  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                    sp_clear  = 1'b1;
                end else if (done_edge) begin
                    state_nxt = S_SHIFT;
                    sp_load   = 1'b1;
                end
`ifdef RESULT_CHECKER_TIMEOUT_EN
                else if (to_hit) begin
                    state_nxt = S_TOUT;
                end
`endif
            end
            S_SHIFT: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                    sp_clear  = 1'b1;
                end else if (sp_finish) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD, S_TOUT: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                    sp_clear  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture registers (kept across a return to IDLE) and display mux.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_cap <= '0;
            h_cap <= '0;
            disp  <= '0;
        end else begin
            if (sp_load) begin
                g_cap <= g;
                h_cap <= h;
            end
            disp <= sel ? g_cap : h_cap;
        end
    end

    // valid and parity register together, one edge after HOLD is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 1'b0;
            parity <= 1'b0;
        end else if (state == S_HOLD && start) begin
            valid  <= 1'b1;
            parity <= odd_parity(pop);
        end else begin
            valid  <= 1'b0;
            parity <= 1'b0;
        end
    end

    serial_pop_count u_pop (
        .clk    (clk),
        .rst    (rst),
        .load   (sp_load),
        .clear  (sp_clear),
        .din    ({g, h}),
        .busy   (sp_busy),
        .finish (sp_finish),
        .pop    (pop)
    );

    // sp_busy is high exactly during SHIFT.
    assign busy      = (state == S_ARMED) || sp_busy;
    assign state_dbg = state;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker. Inputs change right after a falling
// edge; outputs are checked on falling edges.
module tb_result_checker;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_TOUT  = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, done, sel;
    logic [15:0] g, h;
    logic [15:0] disp;
    logic [5:0]  pop;
    logic        parity, valid, busy, timeout;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // Clock / reset
    always #5 clk = ~clk;

    result_checker #(.TIMEOUT_CYCLES(24'd20)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .g         (g),
        .h         (h),
        .sel       (sel),
        .disp      (disp),
        .pop       (pop),
        .parity    (parity),
        .valid     (valid),
        .busy      (busy),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // From ARMED: pulse done low for a cycle, raise it with g/h applied, and
    // follow the 32-cycle SHIFT into HOLD. Optionally toggles done in SHIFT.
    task automatic run_capture(input string tag, input logic [15:0] gv, input logic [15:0] hv,
                               input logic [5:0] exp_pop, input logic exp_par, input bit wiggle);
        done = 1'b0;
        cyc(1);
        g = gv;
        h = hv;
        done = 1'b1;
        cyc(1);                     // capture edge
        chk({tag, "_shift_state"}, state_dbg, ST_SHIFT);
        chk({tag, "_shift_busy"}, busy, 1'b1);
        for (int i = 0; i < 31; i++) begin
            if (wiggle) done = i[0];
            cyc(1);
        end
        chk({tag, "_still_shift"}, state_dbg, ST_SHIFT);
        chk({tag, "_no_early_valid"}, valid, 1'b0);
        cyc(1);                     // 32 edges after capture
        chk({tag, "_hold_state"}, state_dbg, ST_HOLD);
        chk({tag, "_valid_at_32"}, valid, 1'b0);
        chk({tag, "_hold_busy"}, busy, 1'b0);
        cyc(1);                     // 33 edges after capture
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_pop"}, pop, exp_pop);
        chk({tag, "_parity"}, parity, exp_par);
        cyc(3);
        chk({tag, "_valid_held"}, valid, 1'b1);
        chk({tag, "_pop_held"}, pop, exp_pop);
    endtask

    // Drop start, go to IDLE, then re-arm with done low.
    task automatic rearm(input string tag);
        start = 1'b0;
        cyc(1);
        chk({tag, "_idle"}, state_dbg, ST_IDLE);
        chk({tag, "_idle_valid"}, valid, 1'b0);
        chk({tag, "_idle_pop"}, pop, 6'd0);
        chk({tag, "_idle_parity"}, parity, 1'b0);
        done  = 1'b0;
        start = 1'b1;
        cyc(1);
        chk({tag, "_armed"}, state_dbg, ST_ARMED);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; done = 1'b0; sel = 1'b0; g = '0; h = '0;
        cyc(2);
        chk("rst_state", state_dbg, ST_IDLE);
        chk("rst_disp", disp, 16'h0);
        chk("rst_pop", pop, 6'd0);
        chk("rst_parity", parity, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        rst = 1'b1;
        cyc(2);
        chk("idle_wait", state_dbg, ST_IDLE);

        // Case 1
        start = 1'b1;
        cyc(1);
        chk("c1_armed", state_dbg, ST_ARMED);
        chk("c1_armed_busy", busy, 1'b1);
        run_capture("c1", 16'hFFFF, 16'h0000, 6'd16, 1'b1, 1'b0);
        chk("c1_disp_h", disp, 16'h0000);

        // Case 2, with done toggling during SHIFT
        rearm("c2");
        run_capture("c2", 16'h0001, 16'h8000, 6'd2, 1'b1, 1'b1);
        chk("c2_disp_h", disp, 16'h8000);
        sel = 1'b1;
        chk("c2_disp_before_edge", disp, 16'h8000);
        cyc(1);
        chk("c2_disp_g", disp, 16'h0001);
        sel = 1'b0;
        cyc(1);
        chk("c2_disp_h_again", disp, 16'h8000);
        done = 1'b0; cyc(1); done = 1'b1; cyc(2);
        chk("c2_no_recapture", state_dbg, ST_HOLD);
        chk("c2_pop_after_done", pop, 6'd2);

        // Case 3
        rearm("c3a");
        run_capture("c3a", 16'hFFFF, 16'hFFFF, 6'd32, 1'b1, 1'b0);
        rearm("c3b");
        run_capture("c3b", 16'h0007, 16'h0000, 6'd3, 1'b0, 1'b0);

        // Case 4: abort at SHIFT cycle 10
        rearm("c4");
        cyc(1);
        g = 16'h1234; h = 16'hABCD; done = 1'b1;
        cyc(1);
        chk("c4_shift", state_dbg, ST_SHIFT);
        cyc(10);
        chk("c4_partial_pop", pop, 6'd2);
        start = 1'b0;
        cyc(1);
        chk("c4_idle", state_dbg, ST_IDLE);
        chk("c4_pop", pop, 6'd0);
        chk("c4_busy", busy, 1'b0);
        cyc(30);
        chk("c4_valid_never", valid, 1'b0);
        chk("c4_disp_h", disp, 16'hABCD);
        sel = 1'b1;
        cyc(1);
        chk("c4_disp_g", disp, 16'h1234);
        sel = 1'b0;

        // Case 5: done high before start
        done = 1'b1;
        cyc(1);
        start = 1'b1;
        cyc(6);
        chk("c5_stuck_armed", state_dbg, ST_ARMED);
        chk("c5_no_valid", valid, 1'b0);
        run_capture("c5", 16'h00F0, 16'h0F00, 6'd8, 1'b1, 1'b0);

        // Case 6: timeout
        start = 1'b0;
        done  = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        chk("c6_armed", state_dbg, ST_ARMED);
        cyc(19);
        chk("c6_armed_19", state_dbg, ST_ARMED);
        chk("c6_timeout_19", timeout, 1'b0);
        cyc(1);
`ifdef RESULT_CHECKER_TIMEOUT_EN
        chk("c6_tout_state", state_dbg, ST_TOUT);
        chk("c6_timeout", timeout, 1'b1);
        chk("c6_tout_busy", busy, 1'b0);
        cyc(10);
        chk("c6_timeout_held", timeout, 1'b1);
`else
        chk("c6_no_tout", state_dbg, ST_ARMED);
        chk("c6_timeout_off", timeout, 1'b0);
        cyc(10);
        chk("c6_timeout_off_late", timeout, 1'b0);
        chk("c6_still_busy", busy, 1'b1);
`endif
        start = 1'b0;
        cyc(1);
        chk("c6_cleared", timeout, 1'b0);
        chk("c6_idle", state_dbg, ST_IDLE);

        // Case 7: reset mid-SHIFT
        done  = 1'b0;
        start = 1'b1;
        cyc(1);
        g = 16'hFFFF; h = 16'hFFFF; done = 1'b1;
        cyc(6);
        chk("c7_shift", state_dbg, ST_SHIFT);
        #2 rst = 1'b0;
        #1;
        chk("c7_rst_state", state_dbg, ST_IDLE);
        chk("c7_rst_pop", pop, 6'd0);
        chk("c7_rst_busy", busy, 1'b0);
        chk("c7_rst_disp", disp, 16'h0);
        cyc(1);
        start = 1'b0;
        rst = 1'b1;
        cyc(40);
        chk("c7_no_valid", valid, 1'b0);
        chk("c7_idle", state_dbg, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd10_000_000, which sets how many cycles ARMED waits for done before flagging timeout.
REQ-002 SHALL have port clk, input, 1, the single system clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low (rst==0 resets).
REQ-004 SHALL have port start, input, 1, the level-held run request driven to the compute stage.
REQ-005 SHALL have port done, input, 1, the completion flag from the compute stage.
REQ-006 SHALL have ports g and h, input, 16 each, the compute-stage results.
REQ-007 SHALL have port sel, input, 1, display select: 1 shows g, 0 shows h.
REQ-008 SHALL have port disp, output, 16, the registered selected captured result.
REQ-009 SHALL have port pop, output, 6, the population count of {g_cap,h_cap}.
REQ-010 SHALL have port parity, output, 1, the odd-parity bit, so that pop plus parity is odd.
REQ-011 SHALL have ports valid, busy and timeout, output, 1 each, as status flags.

Function
REQ-012 SHALL implement FSM states IDLE, ARMED, SHIFT, HOLD and TOUT.
REQ-013 IDLE SHALL go to ARMED on the edge where start==1.
REQ-014 In ARMED, a done rising edge (done==1 and the registered done_q==0) SHALL capture g_cap=g, h_cap=h, shreg={g,h}, cnt=0 and pop=0, then go to SHIFT.
REQ-015 If done is already high on entry to ARMED, it SHALL NOT count as a rising edge; a fresh 0->1 transition is required.
REQ-016 Each SHIFT cycle SHALL do pop+=shreg[31], shreg<<=1 and cnt+=1 (5-bit); when cnt==31 the FSM SHALL go to HOLD, so SHIFT lasts exactly 32 cycles.
REQ-017 valid SHALL be 1 only in HOLD, rising 33 edges after the capture edge; parity SHALL equal ~pop[0], registered together with valid.
REQ-018 busy SHALL be 1 in ARMED and SHIFT, and 0 otherwise.
REQ-019 disp SHALL equal sel ? g_cap : h_cap, registered every cycle in all states, with one-cycle latency from a sel change.
REQ-020 A start==0 in ARMED, SHIFT, HOLD or TOUT SHALL return the FSM to IDLE next edge and clear valid, timeout, pop and parity.
REQ-021 g_cap and h_cap SHALL be retained on that return to IDLE.
REQ-022 done toggling during SHIFT or HOLD SHALL be ignored; no recapture occurs.
REQ-023 pop SHALL be 6-bit unsigned, with a maximum of 32; no overflow is possible.

Reset
REQ-024 On rst==0: state=IDLE; disp, g_cap, h_cap, shreg, cnt, pop, the timeout counter and done_q SHALL be 0; parity, valid, busy and timeout SHALL be 0.
REQ-025 Reset asserted mid-SHIFT SHALL abort immediately with no partial valid.

Configuration
REQ-026 With macro RESULT_CHECKER_TIMEOUT_EN defined, a 24-bit counter SHALL run in ARMED, cleared on ARMED entry.
REQ-027 With the macro defined, reaching TIMEOUT_CYCLES-1 without a done edge SHALL go to TOUT, and timeout SHALL be 1 until start==0.
REQ-028 Without the macro, no counter SHALL exist, ARMED SHALL wait indefinitely, TOUT SHALL be unreachable, and timeout SHALL be tied to 0.

Structure
REQ-029 Package result_checker_pkg SHALL hold the state encoding constants (3-bit), DATA_W=16, POP_W=6 and the TIMEOUT_CYCLES default.
REQ-030 The serial accumulate logic (shreg, cnt, pop) SHALL be sub-module serial_pop_count, with load, busy and finish handshake.
REQ-031 The FSM, capture registers and display mux SHALL remain in the top level.

Verification
REQ-032 Case 1: start=1, then done 0->1 with g=16'hFFFF, h=16'h0000 -> 33 edges later valid=1, pop=16, parity=1; busy=0 in HOLD.
REQ-033 Case 2: g=16'h0001, h=16'h8000 -> pop=2, parity=1; sel=1 gives disp=16'h0001 and sel=0 gives disp=16'h8000 one edge later.
REQ-034 Case 3: g=16'hFFFF, h=16'hFFFF -> pop=32, parity=1; g=16'h0007, h=16'h0000 -> pop=3, parity=0.
REQ-035 Case 4: start dropped at SHIFT cycle 10 -> IDLE next edge, valid never rises, pop=0, and disp still shows the captured value.
REQ-036 Case 5: done held high before start rises -> FSM stays in ARMED; done pulsed low then high -> capture proceeds.
REQ-037 Case 6: with RESULT_CHECKER_TIMEOUT_EN and TIMEOUT_CYCLES=20, no done -> timeout=1 after 20 ARMED cycles and cleared by start=0; without the macro, timeout stays 0.
